// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: widths, opcodes,
// IR field positions, FSM state encoding and ALU one-hot bit indices.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int NREG        = 16;
    localparam int RIDX_W      = 4;
    localparam int OP_W        = 5;
    localparam int ALU_W       = 13;
    localparam int MEM_TIMEOUT = 15;
    localparam int TMO_W       = 4;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_AND  = 5'd2;
    localparam logic [OP_W-1:0] OP_OR   = 5'd3;
    localparam logic [OP_W-1:0] OP_ROR  = 5'd4;
    localparam logic [OP_W-1:0] OP_ROL  = 5'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd6;
    localparam logic [OP_W-1:0] OP_SHRA = 5'd7;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd8;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd9;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd10;
    localparam logic [OP_W-1:0] OP_NEG  = 5'd11;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd12;
    localparam logic [OP_W-1:0] OP_NOP  = 5'd30;
    localparam logic [OP_W-1:0] OP_HALT = 5'd31;

    // ALU select bus is ordered SHRA at bit 0 up to AND at bit 12
    localparam int ALU_SHRA = 0;
    localparam int ALU_SHR  = 1;
    localparam int ALU_SHL  = 2;
    localparam int ALU_DIV  = 3;
    localparam int ALU_ROL  = 4;
    localparam int ALU_ROR  = 5;
    localparam int ALU_MUL  = 6;
    localparam int ALU_ADD  = 7;
    localparam int ALU_SUB  = 8;
    localparam int ALU_NOT  = 9;
    localparam int ALU_NEG  = 10;
    localparam int ALU_OR   = 11;
    localparam int ALU_AND  = 12;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_R3A, S_R4A, S_R5A,
        S_MD3, S_MD4, S_MD5, S_MD6,
        S_U3, S_U4, S_HALT
    } state_t;

    typedef enum logic [1:0] {SEL_RA, SEL_RB, SEL_RC} reg_sel_t;

    function automatic logic [ALU_W-1:0] alu_onehot(input logic [OP_W-1:0] op);
        logic [ALU_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r[ALU_ADD]  = 1'b1;
            OP_SUB:  r[ALU_SUB]  = 1'b1;
            OP_AND:  r[ALU_AND]  = 1'b1;
            OP_OR:   r[ALU_OR]   = 1'b1;
            OP_ROR:  r[ALU_ROR]  = 1'b1;
            OP_ROL:  r[ALU_ROL]  = 1'b1;
            OP_SHR:  r[ALU_SHR]  = 1'b1;
            OP_SHRA: r[ALU_SHRA] = 1'b1;
            OP_SHL:  r[ALU_SHL]  = 1'b1;
            OP_MUL:  r[ALU_MUL]  = 1'b1;
            OP_DIV:  r[ALU_DIV]  = 1'b1;
            OP_NEG:  r[ALU_NEG]  = 1'b1;
            OP_NOT:  r[ALU_NOT]  = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [RIDX_W-1:0] field_sel(input reg_sel_t sel,
                                                    input logic [RIDX_W-1:0] ra,
                                                    input logic [RIDX_W-1:0] rb,
                                                    input logic [RIDX_W-1:0] rc);
        case (sel)
            SEL_RA:  return ra;
            SEL_RB:  return rb;
            default: return rc;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer (master) and the register-bus datapath
// (slave): run/resume/mem_rdy/IR in, register and ALU strobes out.
interface control_sequencer_if;
    import cpu_pkg::*;

    logic            run;
    logic            resume;
    logic            mem_rdy;
    logic [XLEN-1:0] ir;
    logic [NREG-1:0] reg_in;
    logic [NREG-1:0] reg_out;
    logic [ALU_W-1:0] alu_op;
    logic pc_in, pc_out, inc_pc, ir_in, y_in, z_in, mar_in, mdr_in, mdr_out, read;
    logic hi_in, lo_in, zhi_out, zlo_out;
    logic halted;
    logic err;

    modport master (
        input  run, resume, mem_rdy, ir,
        output reg_in, reg_out, alu_op, pc_in, pc_out, inc_pc, ir_in, y_in, z_in,
               mar_in, mdr_in, mdr_out, read, hi_in, lo_in, zhi_out, zlo_out,
               halted, err
    );

    modport slave (
        output run, resume, mem_rdy, ir,
        input  reg_in, reg_out, alu_op, pc_in, pc_out, inc_pc, ir_in, y_in, z_in,
               mar_in, mdr_in, mdr_out, read, hi_in, lo_in, zhi_out, zlo_out,
               halted, err
    );
endinterface

// File: rtl/control_sequencer_reg_sel_decoder.sv
// 4-bit register index plus enable to a one-hot R0..R15 strobe vector.
module reg_sel_decoder
    import cpu_pkg::*;
(
    input  logic [RIDX_W-1:0] idx,
    input  logic              en,
    output logic [NREG-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch via PC/MAR/MDR, decode IR, then step the
// T-states that strobe the register bus, ALU and Y/Z/HI/LO registers.
//
// state  | meaning
// IDLE   | waiting for run           FETCH0 | PC->MAR, PC+1->Z
// FETCH1 | Z->PC, memory read wait   FETCH2 | MDR->IR
// DECODE | dispatch on opcode        R3A..R5A | 3-register ALU op
// MD3..MD6 | MUL/DIV into HI/LO      U3,U4  | unary NEG/NOT
// HALT   | stopped until resume
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus
);

    state_t             state, state_nxt, end_nxt;
    logic [TMO_W-1:0]   wait_cnt;
    logic               err_q, err_set, tmo_hit;
    logic [OP_W-1:0]    op;
    logic [RIDX_W-1:0]  ra, rb, rc;
    logic               in_en, out_en;
    reg_sel_t           in_sel, out_sel;
    logic               unused_ir;

    assign op        = bus.ir[OP_MSB:OP_LSB];
    assign ra        = bus.ir[RA_MSB:RA_LSB];
    assign rb        = bus.ir[RB_MSB:RB_LSB];
    assign rc        = bus.ir[RC_MSB:RC_LSB];
    assign unused_ir = ^bus.ir[RC_LSB-1:0];
    assign end_nxt   = bus.run ? S_FETCH0 : S_IDLE;
    assign tmo_hit   = (wait_cnt == TMO_W'(MEM_TIMEOUT));
    assign bus.err   = err_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH1 && !bus.mem_rdy && !tmo_hit) wait_cnt <= wait_cnt + 1'b1;
            else                                               wait_cnt <= '0;
            if (err_set) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        case (state)
            S_IDLE:   if (bus.run) state_nxt = S_FETCH0;
            S_FETCH0: state_nxt = S_FETCH1;
            S_FETCH1: begin
                // a late mem_rdy on the timeout cycle still completes the fetch
                if (bus.mem_rdy) state_nxt = S_FETCH2;
                else if (tmo_hit) begin
                    state_nxt = S_HALT;
                    err_set   = 1'b1;
                end
            end
            S_FETCH2: state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
                    OP_SHRA, OP_SHL: state_nxt = S_R3A;
                    OP_MUL, OP_DIV:  state_nxt = S_MD3;
                    OP_NEG, OP_NOT:  state_nxt = S_U3;
                    OP_NOP:          state_nxt = end_nxt;
                    OP_HALT:         state_nxt = S_HALT;
                    default: begin
                        state_nxt = S_HALT;
                        err_set   = 1'b1;
                    end
                endcase
            end
            S_R3A:  state_nxt = S_R4A;
            S_R4A:  state_nxt = S_R5A;
            S_R5A:  state_nxt = end_nxt;
            S_MD3:  state_nxt = S_MD4;
            S_MD4:  state_nxt = S_MD5;
            S_MD5:  state_nxt = S_MD6;
            S_MD6:  state_nxt = end_nxt;
            S_U3:   state_nxt = S_U4;
            S_U4:   state_nxt = end_nxt;
            S_HALT: if (bus.resume) state_nxt = S_FETCH0;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_en       = 1'b0;
        out_en      = 1'b0;
        in_sel      = SEL_RA;
        out_sel     = SEL_RA;
        bus.alu_op  = '0;
        bus.pc_in   = 1'b0;
        bus.pc_out  = 1'b0;
        bus.inc_pc  = 1'b0;
        bus.ir_in   = 1'b0;
        bus.y_in    = 1'b0;
        bus.z_in    = 1'b0;
        bus.mar_in  = 1'b0;
        bus.mdr_in  = 1'b0;
        bus.mdr_out = 1'b0;
        bus.read    = 1'b0;
        bus.hi_in   = 1'b0;
        bus.lo_in   = 1'b0;
        bus.zhi_out = 1'b0;
        bus.zlo_out = 1'b0;
        bus.halted  = 1'b0;
        case (state)
            S_FETCH0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.inc_pc = 1'b1;
                bus.z_in   = 1'b1;
            end
            S_FETCH1: begin
                bus.zlo_out = 1'b1;
                bus.pc_in   = 1'b1;
                bus.read    = 1'b1;
                bus.mdr_in  = 1'b1;
            end
            S_FETCH2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
            end
            S_R3A: begin
                out_en   = 1'b1;
                out_sel  = SEL_RB;
                bus.y_in = 1'b1;
            end
            S_R4A: begin
                out_en     = 1'b1;
                out_sel    = SEL_RC;
                bus.alu_op = alu_onehot(op);
                bus.z_in   = 1'b1;
            end
            S_R5A, S_U4: begin
                bus.zlo_out = 1'b1;
                in_en       = 1'b1;
            end
            S_MD3: begin
                out_en   = 1'b1;
                bus.y_in = 1'b1;
            end
            S_MD4, S_U3: begin
                out_en     = 1'b1;
                out_sel    = SEL_RB;
                bus.alu_op = alu_onehot(op);
                bus.z_in   = 1'b1;
            end
            S_MD5: begin
                bus.zlo_out = 1'b1;
                bus.lo_in   = 1'b1;
            end
            S_MD6: begin
                bus.zhi_out = 1'b1;
                bus.hi_in   = 1'b1;
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end

    reg_sel_decoder u_reg_in_dec (
        .idx    (field_sel(in_sel, ra, rb, rc)),
        .en     (in_en),
        .onehot (bus.reg_in)
    );

    reg_sel_decoder u_reg_out_dec (
        .idx    (field_sel(out_sel, ra, rb, rc)),
        .en     (out_en),
        .onehot (bus.reg_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector bench for control_sequencer: a cycle table for the main
// instruction flows plus hand-written timeout, halt, illegal-op and reset sequences.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic [12:0] alu;
        logic [13:0] stb;
        logic        halted;
        logic        err;
    } out_t;

    typedef struct {
        logic        run;
        logic        mem_rdy;
        logic [31:0] ir;
        out_t        exp;
    } vec_t;

    localparam logic [13:0] PC_IN   = 14'h2000;
    localparam logic [13:0] PC_OUT  = 14'h1000;
    localparam logic [13:0] INC_PC  = 14'h0800;
    localparam logic [13:0] IR_IN   = 14'h0400;
    localparam logic [13:0] Y_IN    = 14'h0200;
    localparam logic [13:0] Z_IN    = 14'h0100;
    localparam logic [13:0] MAR_IN  = 14'h0080;
    localparam logic [13:0] MDR_IN  = 14'h0040;
    localparam logic [13:0] MDR_OUT = 14'h0020;
    localparam logic [13:0] READ    = 14'h0010;
    localparam logic [13:0] HI_IN   = 14'h0008;
    localparam logic [13:0] LO_IN   = 14'h0004;
    localparam logic [13:0] ZHI_OUT = 14'h0002;
    localparam logic [13:0] ZLO_OUT = 14'h0001;
    localparam logic [13:0] F0S = PC_OUT | MAR_IN | INC_PC | Z_IN;
    localparam logic [13:0] F1S = ZLO_OUT | PC_IN | READ | MDR_IN;
    localparam logic [13:0] F2S = MDR_OUT | IR_IN;
    localparam out_t Z = '0;

    logic clk;
    logic clr;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];

    control_sequencer_if bus();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    function automatic out_t ex(input logic [15:0] ri, input logic [15:0] ro,
                                input logic [12:0] al, input logic [13:0] s,
                                input logic h, input logic e);
        out_t o;
        o.reg_in = ri; o.reg_out = ro; o.alu = al; o.stb = s; o.halted = h; o.err = e;
        return o;
    endfunction

    function automatic out_t actual();
        out_t o;
        o.reg_in  = bus.reg_in;
        o.reg_out = bus.reg_out;
        o.alu     = bus.alu_op;
        o.stb     = {bus.pc_in, bus.pc_out, bus.inc_pc, bus.ir_in, bus.y_in, bus.z_in,
                     bus.mar_in, bus.mdr_in, bus.mdr_out, bus.read, bus.hi_in, bus.lo_in,
                     bus.zhi_out, bus.zlo_out};
        o.halted  = bus.halted;
        o.err     = bus.err;
        return o;
    endfunction

    task automatic check(input string nm, input out_t e);
        out_t a;
        a = actual();
        n_vec++;
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s: got ri=%h ro=%h alu=%h stb=%h halted=%b err=%b, want ri=%h ro=%h alu=%h stb=%h halted=%b err=%b",
                     nm, a.reg_in, a.reg_out, a.alu, a.stb, a.halted, a.err,
                     e.reg_in, e.reg_out, e.alu, e.stb, e.halted, e.err);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then check the state's outputs.
    task automatic step(input logic r, input logic rs, input logic m, input logic [31:0] i,
                        input out_t e, input string nm);
        @(negedge clk);
        bus.run = r; bus.resume = rs; bus.mem_rdy = m; bus.ir = i;
        #1;
        check(nm, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        bus.run = 1'b0; bus.resume = 1'b0; bus.mem_rdy = 1'b0; bus.ir = '0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    function automatic void add(input logic r, input logic m, input logic [31:0] i, input out_t e);
        vec_t v;
        v.run = r; v.mem_rdy = m; v.ir = i; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic void add_fetch(input logic [31:0] i);
        add(1'b1, 1'b1, i, ex(0, 0, 0, F0S, 0, 0));
        add(1'b1, 1'b1, i, ex(0, 0, 0, F1S, 0, 0));
        add(1'b1, 1'b1, i, ex(0, 0, 0, F2S, 0, 0));
        add(1'b1, 1'b1, i, Z);
    endfunction

    initial begin
        logic [31:0] i_add, i_mul, i_neg, i_sub, i_nop, i_shl, i_halt, i_bad;
        i_add  = mk_ir(5'd0, 4'd1, 4'd2, 4'd3);
        i_mul  = mk_ir(5'd9, 4'd4, 4'd5, 4'd0);
        i_neg  = mk_ir(5'd11, 4'd6, 4'd7, 4'd0);
        i_sub  = mk_ir(5'd1, 4'd2, 4'd2, 4'd2);
        i_nop  = mk_ir(5'd30, 4'd0, 4'd0, 4'd0);
        i_shl  = mk_ir(5'd8, 4'd15, 4'd0, 4'd14);
        i_halt = mk_ir(5'd31, 4'd0, 4'd0, 4'd0);
        i_bad  = mk_ir(5'd20, 4'd1, 4'd1, 4'd1);

        add(1, 1, i_add, Z);
        add_fetch(i_add);
        add(1, 1, i_add, ex(0, 16'h0004, 0, Y_IN, 0, 0));
        add(1, 1, i_add, ex(0, 16'h0008, 13'h0080, Z_IN, 0, 0));
        add(1, 1, i_add, ex(16'h0002, 0, 0, ZLO_OUT, 0, 0));
        add_fetch(i_mul);
        add(1, 1, i_mul, ex(0, 16'h0010, 0, Y_IN, 0, 0));
        add(1, 1, i_mul, ex(0, 16'h0020, 13'h0040, Z_IN, 0, 0));
        add(1, 1, i_mul, ex(0, 0, 0, ZLO_OUT | LO_IN, 0, 0));
        add(1, 1, i_mul, ex(0, 0, 0, ZHI_OUT | HI_IN, 0, 0));
        add_fetch(i_neg);
        add(1, 1, i_neg, ex(0, 16'h0080, 13'h0400, Z_IN, 0, 0));
        add(0, 1, i_neg, ex(16'h0040, 0, 0, ZLO_OUT, 0, 0));
        add(0, 1, i_neg, Z);
        add(1, 1, i_neg, Z);
        add(1, 1, i_sub, ex(0, 0, 0, F0S, 0, 0));
        add(1, 0, i_sub, ex(0, 0, 0, F1S, 0, 0));
        add(1, 1, i_sub, ex(0, 0, 0, F1S, 0, 0));
        add(1, 1, i_sub, ex(0, 0, 0, F2S, 0, 0));
        add(1, 1, i_sub, Z);
        add(1, 1, i_sub, ex(0, 16'h0004, 0, Y_IN, 0, 0));
        add(1, 1, i_sub, ex(0, 16'h0004, 13'h0100, Z_IN, 0, 0));
        add(1, 1, i_sub, ex(16'h0004, 0, 0, ZLO_OUT, 0, 0));
        add_fetch(i_nop);
        add_fetch(i_shl);
        add(1, 1, i_shl, ex(0, 16'h0001, 0, Y_IN, 0, 0));
        add(1, 1, i_shl, ex(0, 16'h4000, 13'h0004, Z_IN, 0, 0));
        add(0, 1, i_shl, ex(16'h8000, 0, 0, ZLO_OUT, 0, 0));
        add(0, 1, i_shl, Z);

        clr = 1'b0;
        bus.run = 1'b0; bus.resume = 1'b0; bus.mem_rdy = 1'b0; bus.ir = '0;
        #1;
        check("reset_state", Z);
        @(negedge clk);
        clr = 1'b1;

        foreach (vecs[k])
            step(vecs[k].run, 1'b0, vecs[k].mem_rdy, vecs[k].ir, vecs[k].exp,
                 $sformatf("vec%0d", k));

        // fetch timeout: 16 cycles in FETCH1 (count 0..15), then HALT with err
        do_reset();
        step(1, 0, 0, i_add, Z, "tmo_idle");
        step(1, 0, 0, i_add, ex(0, 0, 0, F0S, 0, 0), "tmo_f0");
        for (int k = 0; k < 16; k++)
            step(1, 0, 0, i_add, ex(0, 0, 0, F1S, 0, 0), $sformatf("tmo_wait%0d", k));
        step(1, 0, 0, i_add, ex(0, 0, 0, 0, 1, 1), "tmo_halt");
        step(0, 1, 0, i_add, ex(0, 0, 0, 0, 1, 1), "tmo_resume");
        step(0, 0, 1, i_add, ex(0, 0, 0, F0S, 0, 1), "tmo_f0_err");
        step(0, 0, 1, i_add, ex(0, 0, 0, F1S, 0, 1), "tmo_f1_err");

        // mem_rdy on the timeout cycle wins, then HALT opcode holds through run toggling
        do_reset();
        step(1, 0, 0, i_halt, Z, "win_idle");
        step(1, 0, 0, i_halt, ex(0, 0, 0, F0S, 0, 0), "win_f0");
        for (int k = 0; k < 15; k++)
            step(1, 0, 0, i_halt, ex(0, 0, 0, F1S, 0, 0), $sformatf("win_wait%0d", k));
        step(1, 0, 1, i_halt, ex(0, 0, 0, F1S, 0, 0), "win_rdy");
        step(1, 0, 1, i_halt, ex(0, 0, 0, F2S, 0, 0), "win_f2");
        step(1, 0, 1, i_halt, Z, "halt_decode");
        for (int k = 0; k < 20; k++)
            step(logic'(k % 2), 0, 1, i_halt, ex(0, 0, 0, 0, 1, 0), $sformatf("halt_hold%0d", k));
        step(0, 1, 1, i_halt, ex(0, 0, 0, 0, 1, 0), "halt_resume");
        step(0, 0, 1, i_halt, ex(0, 0, 0, F0S, 0, 0), "halt_f0");

        // illegal opcode
        do_reset();
        step(1, 0, 1, i_bad, Z, "ill_idle");
        step(1, 0, 1, i_bad, ex(0, 0, 0, F0S, 0, 0), "ill_f0");
        step(1, 0, 1, i_bad, ex(0, 0, 0, F1S, 0, 0), "ill_f1");
        step(1, 0, 1, i_bad, ex(0, 0, 0, F2S, 0, 0), "ill_f2");
        step(1, 0, 1, i_bad, Z, "ill_decode");
        step(1, 0, 1, i_bad, ex(0, 0, 0, 0, 1, 1), "ill_halt");
        step(1, 0, 1, i_bad, ex(0, 0, 0, 0, 1, 1), "ill_halt_run");

        // asynchronous reset in the middle of R4A
        do_reset();
        step(1, 0, 1, i_add, Z, "rst_idle");
        step(1, 0, 1, i_add, ex(0, 0, 0, F0S, 0, 0), "rst_f0");
        step(1, 0, 1, i_add, ex(0, 0, 0, F1S, 0, 0), "rst_f1");
        step(1, 0, 1, i_add, ex(0, 0, 0, F2S, 0, 0), "rst_f2");
        step(1, 0, 1, i_add, Z, "rst_decode");
        step(1, 0, 1, i_add, ex(0, 16'h0004, 0, Y_IN, 0, 0), "rst_r3a");
        step(1, 0, 1, i_add, ex(0, 16'h0008, 13'h0080, Z_IN, 0, 0), "rst_r4a");
        clr = 1'b0;
        #1;
        check("rst_async", Z);
        @(negedge clk);
        bus.run = 1'b0;
        clr = 1'b1;
        for (int k = 0; k < 3; k++)
            step(0, 0, 1, i_add, Z, $sformatf("rst_stay_idle%0d", k));
        step(1, 0, 1, i_add, Z, "rst_idle_run");
        step(1, 0, 1, i_add, ex(0, 0, 0, F0S, 0, 0), "rst_restart_f0");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
